mantissa_align_shifter: RTL and testbench
=========================================

MANTISSA_ALIGN_SHIFTER -- requirements
Module: mantissa_align_shifter

Interface
REQ-001 SHALL have parameter STEP, default 8, max right-shift bits per cycle (legal 1..16).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand valid.
REQ-005 SHALL have port in_ready  output  1  block idle, can accept an operand.
REQ-006 SHALL have port Input_Mantissa  input  53  mantissa with hidden bit at [52].
REQ-007 SHALL have port Input_Exp  input  11  biased exponent of operand.
REQ-008 SHALL have port Target_Exp  input  11  exponent to align to.
REQ-009 SHALL have port out_valid  output  1  aligned result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port Output_Mantissa  output  53  right-shifted mantissa.
REQ-012 SHALL have port Output_Exp  output  11  result exponent.
REQ-013 SHALL have ports guard, round, sticky  output  1 each  first, second, OR-of-remaining bits shifted out.

Function
REQ-014 SHALL implement FSM IDLE, SHIFT, DONE; in_ready = (state==IDLE).
REQ-015 On edge with in_valid&&in_ready (edge k): capture mantissa; clear guard/round/sticky; Output_Exp = max(Input_Exp, Target_Exp); rem = min(Target_Exp-Input_Exp, 56) if Target_Exp>Input_Exp, else 0.
REQ-016 From IDLE at edge k: go to DONE if rem==0, else SHIFT.
REQ-017 Each SHIFT edge: s = min(rem, STEP); {mantissa,guard,round} shifted right by s; bits dropped past round ORed into sticky (old guard/round included when displaced); rem -= s.
REQ-018 SHIFT to DONE on the edge where rem becomes 0; out_valid rises at edge k+ceil(rem/STEP).
REQ-019 Shift of 56 SHALL leave mantissa 0, guard 0, round 0, sticky = |Input_Mantissa.
REQ-020 In DONE out_valid=1; all outputs held stable while out_ready=0.
REQ-021 DONE to IDLE on edge with out_valid&&out_ready; out_valid low next cycle; no operand accepted on that same edge.
REQ-022 in_valid ignored outside IDLE; Input_* and Target_Exp sampled only at acceptance.
REQ-023 Output_Exp SHALL NOT change during SHIFT; no exponent overflow possible (max of two 11-bit values).

Reset
REQ-024 rst high SHALL asynchronously force state IDLE, out_valid 0, Output_Mantissa 0, Output_Exp 0, guard/round/sticky 0, rem 0; in_ready 1 while and after reset.
REQ-025 rst asserted mid-SHIFT or in DONE SHALL discard the operation with no result delivered.

Configuration
REQ-026 Macro ALIGN_STICKY_EN defined: sticky accumulation per REQ-017/REQ-019.
REQ-027 Macro ALIGN_STICKY_EN undefined: sticky port present, constant 0, no accumulation logic; guard/round unaffected.

Verification
REQ-028 STEP=8, M=bit52 only, Input_Exp=1000, Target_Exp=1004 -> after 1 SHIFT cycle M=bit48 only, Exp=1004, g=r=s=0, out_valid at edge k+1.
REQ-029 M=53'h1F_FFFF_FFFF_FFFF, Input_Exp=0, Target_Exp=3 -> M=53'h03_FFFF_FFFF_FFFF, Exp=3, g=1, r=1, sticky=1 (0 without ALIGN_STICKY_EN).
REQ-030 Target_Exp=10, Input_Exp=20, M=53'h12345 -> passthrough M=53'h12345, Exp=20, g=r=s=0, out_valid at edge k.
REQ-031 M=53'h1, Input_Exp=0, Target_Exp=2000, STEP=8 -> 7 SHIFT cycles, M=0, g=r=0, sticky=1, Exp=2000.
REQ-032 out_ready held 0 for 5 cycles in DONE -> outputs unchanged, in_ready 0; second operand accepted only on edge after handshake.
REQ-033 rst pulsed during SHIFT -> out_valid 0, in_ready 1, all outputs 0 immediately; next operand processed normally.

Source files
------------

// File: rtl/mantissa_align_shifter.sv
// Multi-cycle right-shift aligner: shifts a 53-bit mantissa by up to STEP bits per cycle toward Target_Exp.
// Define ALIGN_STICKY_EN to accumulate shifted-out bits into sticky; otherwise sticky is tied to 0.
module mantissa_align_shifter #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [52:0] Input_Mantissa,
  input  logic [10:0] Input_Exp,
  input  logic [10:0] Target_Exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [52:0] Output_Mantissa,
  output logic [10:0] Output_Exp,
  output logic        guard,
  output logic        round,
  output logic        sticky
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] STEP_W  = 6'(STEP);
  localparam logic [10:0] MAX_SH = 11'd56;

  state_t      state_q, state_d;
  logic [52:0] m_q, m_d;
  logic        g_q, g_d, r_q, r_d;
  logic [10:0] exp_q, exp_d;
  logic [5:0]  rem_q, rem_d;

  logic [10:0] diff;
  logic [5:0]  rem_init;
  logic [5:0]  step_amt;
  logic [54:0] sh_mgr;

  always_comb begin
    diff     = Target_Exp - Input_Exp;
    rem_init = 6'd0;
    if (Target_Exp > Input_Exp)
      rem_init = (diff > MAX_SH) ? MAX_SH[5:0] : diff[5:0];
    step_amt = (rem_q < STEP_W) ? rem_q : STEP_W;
  end

`ifdef ALIGN_STICKY_EN
  logic        s_q, s_d;
  logic [70:0] ext_sh;
  logic        drop_any;

  // Extra 16 zero bits catch everything pushed past round in one step (STEP <= 16).
  always_comb begin
    ext_sh   = {m_q, g_q, r_q, 16'b0} >> step_amt;
    sh_mgr   = ext_sh[70:16];
    drop_any = |ext_sh[15:0];
  end

  always_comb begin
    s_d = s_q;
    if (state_q == IDLE && in_valid) s_d = 1'b0;
    else if (state_q == SHIFT)       s_d = s_q | drop_any;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_q <= 1'b0;
    else     s_q <= s_d;
  end

  assign sticky = s_q;
`else
  always_comb sh_mgr = {m_q, g_q, r_q} >> step_amt;
  assign sticky = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    g_d     = g_q;
    r_d     = r_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = Input_Mantissa;
          g_d     = 1'b0;
          r_d     = 1'b0;
          exp_d   = (Target_Exp > Input_Exp) ? Target_Exp : Input_Exp;
          rem_d   = rem_init;
          state_d = (rem_init == 6'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        {m_d, g_d, r_d} = sh_mgr;
        rem_d           = rem_q - step_amt;
        if (rem_d == 6'd0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      g_q     <= g_d;
      r_q     <= r_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign Output_Mantissa = m_q;
  assign Output_Exp      = exp_q;
  assign guard           = g_q;
  assign round           = r_q;

endmodule

// File: tb/tb_mantissa_align_shifter.sv
// Randomized + directed bench for mantissa_align_shifter against a whole-shift arithmetic reference.
module tb_mantissa_align_shifter;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [52:0] Input_Mantissa;
  logic [10:0] Input_Exp;
  logic [10:0] Target_Exp;
  logic        out_valid;
  logic        out_ready;
  logic [52:0] Output_Mantissa;
  logic [10:0] Output_Exp;
  logic        guard, round, sticky;

  int checks = 0;
  int errors = 0;

  mantissa_align_shifter #(.STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Input_Mantissa(Input_Mantissa), .Input_Exp(Input_Exp), .Target_Exp(Target_Exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .Output_Mantissa(Output_Mantissa), .Output_Exp(Output_Exp),
    .guard(guard), .round(round), .sticky(sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole shift done at once on a 112-bit value: everything below round folds into sticky.
  task automatic ref_model(input logic [52:0] m, input logic [10:0] ie, input logic [10:0] te,
                           output logic [52:0] om, output logic [10:0] oe,
                           output logic og, output logic orr, output logic os, output int lat);
    int sh;
    logic [111:0] v;
    sh = (te > ie) ? int'(te) - int'(ie) : 0;
    if (sh > 56) sh = 56;
    v   = {m, 59'b0} >> sh;
    om  = v[111:59];
    og  = v[58];
    orr = v[57];
`ifdef ALIGN_STICKY_EN
    os  = |v[56:0];
`else
    os  = 1'b0;
`endif
    oe  = (te > ie) ? te : ie;
    lat = (sh + STEP - 1) / STEP;
  endtask

  // Called in IDLE, 1ns after a rising edge.
  task automatic do_op(input logic [52:0] m, input logic [10:0] ie, input logic [10:0] te, input int hold);
    logic [52:0] em;
    logic [10:0] ee;
    logic eg, er, es;
    int lat, n;
    ref_model(m, ie, te, em, ee, eg, er, es, lat);
    in_valid = 1'b1; Input_Mantissa = m; Input_Exp = ie; Target_Exp = te;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("mant", 64'(Output_Mantissa), 64'(em));
    chk("exp", 64'(Output_Exp), 64'(ee));
    chk("guard", 64'(guard), 64'(eg));
    chk("round", 64'(round), 64'(er));
    chk("sticky", 64'(sticky), 64'(es));
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      Input_Mantissa = {$urandom, $urandom};
      Input_Exp = 11'($urandom);
      Target_Exp = 11'($urandom);
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_mant", 64'(Output_Mantissa), 64'(em));
      chk("hold_exp", 64'(Output_Exp), 64'(ee));
      chk("hold_grs", 64'({guard, round, sticky}), 64'({eg, er, es}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [52:0] rm;
    logic [10:0] ie, te;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Input_Mantissa = '0; Input_Exp = '0; Target_Exp = '0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({Output_Mantissa, Output_Exp}), 64'd0);
    chk("rst_grs", 64'({guard, round, sticky}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("after_rst_ready", 64'(in_ready), 64'd1);

    do_op(53'h10_0000_0000_0000, 11'd1000, 11'd1004, 0);
    do_op(53'h1F_FFFF_FFFF_FFFF, 11'd0, 11'd3, 0);
    do_op(53'h12345, 11'd20, 11'd10, 0);
    do_op(53'h1, 11'd0, 11'd2000, 0);
    do_op(53'h1A_BCDE_F012_3456, 11'd100, 11'd155, 0);
    do_op(53'h15_5555_5555_5555, 11'd500, 11'd509, 5);

    // Reset mid-shift must abort the operation immediately.
    in_valid = 1'b1; Input_Mantissa = 53'h1F_0000_0000_0001; Input_Exp = 11'd0; Target_Exp = 11'd50;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_outputs", 64'({Output_Mantissa, Output_Exp}), 64'd0);
    chk("midrst_grs", 64'({guard, round, sticky}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 64'(out_valid), 64'd0);
    end
    do_op(53'h0F_0F0F_0F0F_0F0F, 11'd7, 11'd30, 0);

    for (int i = 0; i < 40; i++) begin
      rm = {$urandom, $urandom};
      rm[52] = ($urandom_range(0, 3) != 0);
      ie = 11'($urandom_range(0, 2047));
      case ($urandom_range(0, 3))
        0: te = ie;
        1: te = 11'($urandom_range(0, 2047));
        default: te = (int'(ie) + 70 > 2047) ? 11'd2047 : 11'(int'(ie) + $urandom_range(0, 70));
      endcase
      do_op(rm, ie, te, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
